// File: rtl/keypad_scanner_n_pkg.sv
// Shared types and helpers for the parametrised keypad row scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Widest column bus the priority encoder accepts; callers pad unused bits with 1.
    localparam int MAX_COLS = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

    function automatic int lowest_zero_idx(input logic [MAX_COLS-1:0] cols);
        int idx;
        idx = 0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_n_if.sv
// Pin-side and consumer-side signal bundle of the keypad scanner.
interface keypad_scanner_n_if
    import keypad_pkg::*;
#(
    parameter int NROWS = 4,
    parameter int NCOLS = 4
);
    localparam int RW = idx_width(NROWS);
    localparam int CW = idx_width(NCOLS);

    logic [NCOLS-1:0]   columns;
    logic [NROWS-1:0]   rows;
    logic               key_valid;
    logic [RW-1:0]      key_row;
    logic [CW-1:0]      key_col;
    logic [RW+CW-1:0]   key_code;
    logic               key_held;

    modport master (
        input  columns,
        output rows,
        output key_valid,
        output key_row,
        output key_col,
        output key_code,
        output key_held
    );

    modport slave (
        output columns,
        input  rows,
        input  key_valid,
        input  key_row,
        input  key_col,
        input  key_code,
        input  key_held
    );

endinterface

// File: rtl/keypad_scanner_n_stable_counter.sv
// Saturating cycle counter with synchronous clear and a threshold-reached flag.
module keypad_stable_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] threshold,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = (count_reg >= threshold);

endmodule

// File: rtl/keypad_scanner_n.sv
// One-hot row scanner with settle, press/release debounce and one event per press.
// Define KEYPAD_SCANNER_N_AUTOREPEAT_EN to add timed auto-repeat while a key is held.
module keypad_scanner_n
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_scanner_n_if.master   kp
);

    localparam int RW      = idx_width(NROWS);
    localparam int CW      = idx_width(NCOLS);
    localparam int CNT_MAX = max_of(max_of(SETTLE_CYCLES, DEBOUNCE_CYCLES),
                                    max_of(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int CNT_W   = cnt_width(CNT_MAX);

    scan_state_t        state_reg, state_next;
    logic [RW-1:0]      row_reg, row_next, row_wrap;
    logic [CW-1:0]      col_reg, col_next;
    logic [NROWS-1:0]   rows_reg, rows_next;
    logic               key_valid_reg, key_valid_next;
    logic [RW-1:0]      key_row_reg, key_row_next;
    logic [CW-1:0]      key_col_reg, key_col_next;
    logic               key_held_reg, key_held_next;
    logic [MAX_COLS-1:0] cols_ext;
    logic               col_released;
    logic               cnt_clear, cnt_inc, cnt_done;
    logic [CNT_W-1:0]   cnt_thr;

    assign col_released = kp.columns[col_reg];
    assign row_wrap     = (row_reg == RW'(NROWS - 1)) ? '0 : row_reg + 1'b1;

    always_comb begin
        cols_ext              = '1;
        cols_ext[NCOLS-1:0]   = kp.columns;
    end

    generate
        for (genvar gi = 0; gi < NROWS; gi++) begin : g_row_decode
            assign rows_next[gi] = (row_next == RW'(gi));
        end
    endgenerate

    // Settle, press debounce and release debounce never overlap, so one counter serves all three.
    keypad_stable_counter #(.W(CNT_W)) u_phase_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .inc       (cnt_inc),
        .threshold (cnt_thr),
        .done      (cnt_done)
    );

`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
    logic               rep_clear, rep_inc, rep_done;
    logic               rep_first_reg, rep_first_next;
    logic [CNT_W-1:0]   rep_thr;

    // Threshold is one less than the interval: the counter restarts on the pulse edge itself.
    assign rep_thr = rep_first_reg ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);

    keypad_stable_counter #(.W(CNT_W)) u_repeat_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (rep_clear),
        .inc       (rep_inc),
        .threshold (rep_thr),
        .done      (rep_done)
    );
`endif

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        key_valid_next = 1'b0;
        key_row_next   = key_row_reg;
        key_col_next   = key_col_reg;
        key_held_next  = key_held_reg;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        cnt_thr        = CNT_W'(DEBOUNCE_CYCLES);
`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
        rep_clear      = 1'b1;
        rep_inc        = 1'b0;
        rep_first_next = 1'b1;
`endif
        case (state_reg)
            SCAN: begin
                cnt_thr = CNT_W'(SETTLE_CYCLES - 1);
                if (cnt_done) begin
                    cnt_clear = 1'b1;
                    if (&kp.columns) begin
                        row_next = row_wrap;
                    end else begin
                        col_next   = CW'(lowest_zero_idx(cols_ext));
                        state_next = DEBOUNCE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_released) begin
                    cnt_clear  = 1'b1;
                    state_next = SCAN;
                end else if (cnt_done) begin
                    cnt_clear      = 1'b1;
                    state_next     = HELD;
                    key_valid_next = 1'b1;
                    key_row_next   = row_reg;
                    key_col_next   = col_reg;
                    key_held_next  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                if (col_released) begin
                    cnt_clear  = 1'b1;
                    state_next = RELEASE;
                end
`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
                else begin
                    rep_clear      = 1'b0;
                    rep_first_next = rep_first_reg;
                    if (rep_done) begin
                        key_valid_next = 1'b1;
                        rep_clear      = 1'b1;
                        rep_first_next = 1'b0;
                    end else begin
                        rep_inc = 1'b1;
                    end
                end
`endif
            end
            RELEASE: begin
                if (!col_released) begin
                    cnt_clear = 1'b1;
                end else if (cnt_done) begin
                    cnt_clear     = 1'b1;
                    key_held_next = 1'b0;
                    row_next      = row_wrap;
                    state_next    = SCAN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                state_next = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= SCAN;
            row_reg       <= '0;
            col_reg       <= '0;
            rows_reg      <= NROWS'(1);
            key_valid_reg <= 1'b0;
            key_row_reg   <= '0;
            key_col_reg   <= '0;
            key_held_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            rows_reg      <= rows_next;
            key_valid_reg <= key_valid_next;
            key_row_reg   <= key_row_next;
            key_col_reg   <= key_col_next;
            key_held_reg  <= key_held_next;
        end
    end

`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_first_reg <= 1'b1;
        end else begin
            rep_first_reg <= rep_first_next;
        end
    end
`endif

    assign kp.rows      = rows_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.key_row   = key_row_reg;
    assign kp.key_col   = key_col_reg;
    assign kp.key_code  = {key_row_reg, key_col_reg};
    assign kp.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Self-checking bench for keypad_scanner_n: keypad matrix model, event scoreboard, vector table.
module tb_keypad_scanner_n;

    localparam int SETTLE  = 2;
    localparam int DEB     = 8;
    localparam int RDELAY  = 20;
    localparam int RPERIOD = 10;
    localparam int LAT     = SETTLE + DEB + 1;
`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
    localparam int EXP_REPEATS_45 = 3;
`else
    localparam int EXP_REPEATS_45 = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_n_if #(.NROWS(4), .NCOLS(4)) kp ();

    keypad_scanner_n #(
        .NROWS(4), .NCOLS(4), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Physical keypad: a pressed key pulls its column low while its row is driven.
    logic [3:0] press_mask [4];
    logic [3:0] cols_drv;
    always_comb begin
        cols_drv = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (kp.rows[r] && press_mask[r][c]) cols_drv[c] = 1'b0;
            end
        end
    end
    assign kp.columns = cols_drv;

    typedef struct { logic [3:0] code; int lat; int at; } exp_t;
    typedef struct { int row; int col; int hold; logic [3:0] code; } vec_t;

    exp_t exp_q[$];
    exp_t got;
    int checks = 0, failures = 0;
    int cyc = 0, row_since = 0, n_events = 0, last_event_cyc = 0;
    logic [3:0] prev_rows = 4'b0001;
    logic rst_at_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input int lat, input int at);
        exp_t e;
        e.code = code;
        e.lat  = lat;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        rst_at_edge = reset;
        #1;
        cyc++;
        if (!rst_at_edge || kp.rows !== prev_rows) row_since = cyc;
        prev_rows = kp.rows;
        if (kp.key_valid === 1'b1) begin
            n_events++;
            last_event_cyc = cyc;
            $display("event cyc=%0d code=%b row=%0d col=%0d", cyc, kp.key_code, kp.key_row, kp.key_col);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual_code=%b required=none", kp.key_code);
            end else begin
                got = exp_q.pop_front();
                check("event_code", 32'(kp.key_code), 32'(got.code));
                check("event_row", 32'(kp.key_row), 32'(got.code[3:2]));
                check("event_col", 32'(kp.key_col), 32'(got.code[1:0]));
                if (got.lat >= 0) check("event_latency", cyc - row_since, got.lat);
                if (got.at >= 0) check("event_cycle", cyc, got.at);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_event(input string name, input int budget);
        int start;
        int k;
        start = n_events;
        k = 0;
        while (n_events == start && k < budget) begin
            step(1);
            k++;
        end
        if (n_events == start) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_event_in_%0d_cycles required=event", name, budget);
        end
    endtask

    task automatic wait_release(input string name, input int lo, input int hi);
        int k;
        k = 0;
        while (kp.key_held === 1'b1 && k < hi + 20) begin
            step(1);
            k++;
        end
        checks++;
        if (kp.key_held !== 1'b0 || k < lo || k > hi) begin
            failures++;
            $display("FAIL %s actual_cycles=%0d held=%b required=%0d..%0d", name, k, kp.key_held, lo, hi);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        logic [3:0] exp_rows;
        logic held_ok;
        int t0, ev_before;

        vecs[0] = '{row: 2, col: 1, hold: 30, code: 4'b1001};
        vecs[1] = '{row: 0, col: 0, hold: 20, code: 4'b0000};
        vecs[2] = '{row: 3, col: 3, hold: 15, code: 4'b1111};
        vecs[3] = '{row: 1, col: 2, hold: 25, code: 4'b0110};
        for (int r = 0; r < 4; r++) press_mask[r] = 4'b0000;

        reset = 1'b0;
        step(3);
        check("reset_rows", 32'(kp.rows), 32'b0001);
        check("reset_key_valid", 32'(kp.key_valid), 0);
        check("reset_key_held", 32'(kp.key_held), 0);
        check("reset_key_code", 32'(kp.key_code), 0);

        // Idle scan: each row driven for SETTLE cycles in order.
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step(1);
            exp_rows = 4'b0001 << ((k / 2) % 4);
            check("idle_rows", 32'(kp.rows), 32'(exp_rows));
            if (k == 0) reset = 1'b1;
        end

        for (int i = 0; i < 4; i++) begin
            push_exp(vecs[i].code, LAT, -1);
            press_mask[vecs[i].row][vecs[i].col] = 1'b1;
            wait_event("table_event", 100);
            t0 = last_event_cyc;
`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
            for (int x = RDELAY; x <= vecs[i].hold; x += RPERIOD) push_exp(vecs[i].code, -1, t0 + x);
`endif
            held_ok = 1'b1;
            for (int h = 0; h < vecs[i].hold; h++) begin
                if (kp.rows !== (4'b0001 << vecs[i].row) || kp.key_held !== 1'b1) held_ok = 1'b0;
                step(1);
            end
            check("table_held_frozen", 32'(held_ok), 1);
            press_mask[vecs[i].row][vecs[i].col] = 1'b0;
            wait_release("table_release", DEB + 1, DEB + 2);
            step(3);
        end

        // Bouncing contact on row 1 col 3, then stable.
        for (int t = 0; t < 20; t++) begin
            if (t % 3 == 0) press_mask[1][3] = ~press_mask[1][3];
            step(1);
        end
        press_mask[1][3] = 1'b1;
        push_exp(4'b0111, -1, -1);
        wait_event("bounce_event", 100);
        step(5);
        press_mask[1][3] = 1'b0;
        wait_release("bounce_release", DEB + 1, DEB + 2);
        step(3);

        // Two keys in row 1: lowest column first, the other after release and rescan.
        push_exp(4'b0101, LAT, -1);
        press_mask[1][1] = 1'b1;
        press_mask[1][2] = 1'b1;
        wait_event("rollover_first", 100);
        step(5);
        push_exp(4'b0110, LAT, -1);
        press_mask[1][1] = 1'b0;
        wait_release("rollover_release", DEB + 1, DEB + 2);
        wait_event("rollover_second", 100);
        step(5);
        press_mask[1][2] = 1'b0;
        wait_release("rollover_second_release", DEB + 1, DEB + 2);
        step(3);

        // Reset while HELD.
        push_exp(4'b1000, LAT, -1);
        press_mask[2][0] = 1'b1;
        wait_event("reset_held_event", 100);
        step(3);
        reset = 1'b0;
        press_mask[2][0] = 1'b0;
        step(1);
        check("held_reset_rows", 32'(kp.rows), 32'b0001);
        check("held_reset_key_held", 32'(kp.key_held), 0);
        check("held_reset_key_valid", 32'(kp.key_valid), 0);
        check("held_reset_key_code", 32'(kp.key_code), 0);
        reset = 1'b1;
        ev_before = n_events;
        step(30);
        check("recovery_events", n_events - ev_before, 0);

        // Long hold: repeats only when auto-repeat is built in.
        push_exp(4'b1101, LAT, -1);
        press_mask[3][1] = 1'b1;
        wait_event("hold45_event", 100);
        t0 = last_event_cyc;
`ifdef KEYPAD_SCANNER_N_AUTOREPEAT_EN
        for (int x = RDELAY; x <= 45; x += RPERIOD) push_exp(4'b1101, -1, t0 + x);
`endif
        ev_before = n_events;
        step(45);
        press_mask[3][1] = 1'b0;
        wait_release("hold45_release", DEB + 1, DEB + 2);
        step(20);
        check("hold45_repeat_count", n_events - ev_before, EXP_REPEATS_45);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
